// File: rtl/gp_lpddr5_ca_cmd_encoder.sv
// LPDDR5 controller-side CS/CA command encoder: one command per valid/ready handshake,
// optional CAS prefix on data commands, ACT->REF spacing and refresh-interval tracking.
module gp_lpddr5_ca_cmd_encoder #(
  parameter int unsigned T_ACT_REF = 6,
  parameter int unsigned T_REFI    = 64,
  parameter int unsigned CNT_W     = 16
) (
  input  logic       ck_t,
  input  logic       ddr_reset_n,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [3:0] req_cmd_i,
  input  logic [7:0] req_arg_i,
  input  logic       req_cas_i,
  output logic       cs_o,
  output logic [6:0] ca_o,
  output logic       pd_o,
  output logic       ref_due_o,
  output logic       ref_overdue_o,
  output logic       err_o
);

  localparam int unsigned      GW       = $clog2(T_ACT_REF + 1);
  localparam logic [GW-1:0]    GuardMax = GW'(T_ACT_REF);
  localparam logic [CNT_W-1:0] RefDue   = CNT_W'(T_REFI);
  localparam logic [CNT_W-1:0] RefMax   = CNT_W'(2 * T_REFI);

  localparam logic [3:0] CmdNop   = 4'd0;
  localparam logic [3:0] CmdAct   = 4'd1;
  localparam logic [3:0] CmdPre   = 4'd2;
  localparam logic [3:0] CmdRef   = 4'd3;
  localparam logic [3:0] CmdWr16  = 4'd4;
  localparam logic [3:0] CmdWr32  = 4'd5;
  localparam logic [3:0] CmdMwr   = 4'd6;
  localparam logic [3:0] CmdRd16  = 4'd7;
  localparam logic [3:0] CmdRd32  = 4'd8;
  localparam logic [3:0] CmdMrw   = 4'd9;
  localparam logic [3:0] CmdMrr   = 4'd10;
  localparam logic [3:0] CmdWff   = 4'd11;
  localparam logic [3:0] CmdRff   = 4'd12;
  localparam logic [3:0] CmdCasFs = 4'd13;
  localparam logic [3:0] CmdPde   = 4'd14;
  localparam logic [3:0] CmdPdx   = 4'd15;

  // Patterns held in written order: bit 6 is CA0, bit 0 is CA6.
  localparam logic [6:0] PatNop   = 7'b0000000;
  localparam logic [6:0] PatPre   = 7'b0001111;
  localparam logic [6:0] PatRef   = 7'b0001110;
  localparam logic [6:0] PatMrr   = 7'b0001100;
  localparam logic [6:0] PatWff   = 7'b0000011;
  localparam logic [6:0] PatRff   = 7'b0000010;
  localparam logic [6:0] PatCasFs = 7'b0011001;
  localparam logic [6:0] PatMrw1  = 7'b0001101;
  localparam logic [6:0] PatCasWr = 7'b0011100;
  localparam logic [6:0] PatCasRd = 7'b0011010;
  localparam logic [6:0] PatPwr   = 7'b0000001;

  typedef enum logic [1:0] {StIdle, StBeat2, StPd, StPdxDrive} state_e;

  state_e           state_q, state_d;
  logic             cs_q, cs_d;
  logic [6:0]       pat_q, pat_d;
  logic [6:0]       beat2_q, beat2_d;
  logic             beat2_act_q, beat2_act_d;
  logic             pd_q, pd_d;
  logic             err_q, err_d;
  logic             due_q, overdue_q;
  logic [GW-1:0]    guard_q, guard_d;
  logic [CNT_W-1:0] refcnt_q, refcnt_d;
  logic             accept, ref_clr, act_clr, is_wr;
  logic [6:0]       data_pat;

  assign req_ready_o = ddr_reset_n && (state_q != StBeat2) && (state_q != StPdxDrive) &&
                       !((req_cmd_i == CmdRef) && (guard_q < GuardMax));
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    data_pat = PatNop;
    is_wr    = 1'b0;
    case (req_cmd_i)
      CmdWr16: begin data_pat = {3'b011, req_arg_i[3:0]};  is_wr = 1'b1; end
      CmdWr32: begin data_pat = {4'b0010, req_arg_i[2:0]}; is_wr = 1'b1; end
      CmdMwr:  begin data_pat = {3'b010, req_arg_i[3:0]};  is_wr = 1'b1; end
      CmdRd16: data_pat = {3'b100, req_arg_i[3:0]};
      CmdRd32: data_pat = {3'b101, req_arg_i[3:0]};
      default: data_pat = PatNop;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cs_d        = 1'b0;
    pat_d       = PatNop;
    beat2_d     = beat2_q;
    beat2_act_d = beat2_act_q;
    pd_d        = 1'b0;
    err_d       = 1'b0;
    ref_clr     = 1'b0;
    act_clr     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cs_d = 1'b1;
          case (req_cmd_i)
            CmdNop:   pat_d = PatNop;
            CmdAct: begin
              pat_d       = {3'b111, req_arg_i[7:4]};
              beat2_d     = {3'b110, req_arg_i[3:0]};
              beat2_act_d = 1'b1;
              state_d     = StBeat2;
            end
            CmdPre:   pat_d = PatPre;
            CmdRef: begin
              pat_d   = PatRef;
              ref_clr = 1'b1;
            end
            CmdMrw: begin
              pat_d       = PatMrw1;
              beat2_d     = {6'b000100, req_arg_i[0]};
              beat2_act_d = 1'b0;
              state_d     = StBeat2;
            end
            CmdMrr:   pat_d = PatMrr;
            CmdWff:   pat_d = PatWff;
            CmdRff:   pat_d = PatRff;
            CmdCasFs: pat_d = PatCasFs;
            CmdPde: begin
              pat_d   = PatPwr;
              state_d = StPd;
            end
            CmdPdx: begin
              cs_d  = 1'b0;
              err_d = 1'b1;
            end
            default: begin
              if (req_cas_i) begin
                pat_d       = is_wr ? PatCasWr : PatCasRd;
                beat2_d     = data_pat;
                beat2_act_d = 1'b0;
                state_d     = StBeat2;
              end else begin
                pat_d = data_pat;
              end
            end
          endcase
        end
      end
      StBeat2: begin
        cs_d    = 1'b1;
        pat_d   = beat2_q;
        act_clr = beat2_act_q;
        state_d = StIdle;
      end
      StPd: begin
        pd_d = 1'b1;
        if (accept) begin
          if (req_cmd_i == CmdPdx) begin
            pat_d   = PatPwr;
            state_d = StPdxDrive;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StPdxDrive: state_d = StIdle;
    endcase
  end

  always_comb begin
    guard_d  = act_clr ? '0 : ((guard_q < GuardMax) ? guard_q + 1'b1 : guard_q);
    refcnt_d = ref_clr ? '0 : ((refcnt_q < RefMax) ? refcnt_q + 1'b1 : refcnt_q);
  end

  always_ff @(posedge ck_t or negedge ddr_reset_n) begin
    if (!ddr_reset_n) begin
      state_q     <= StIdle;
      cs_q        <= 1'b0;
      pat_q       <= '0;
      beat2_q     <= '0;
      beat2_act_q <= 1'b0;
      pd_q        <= 1'b0;
      err_q       <= 1'b0;
      due_q       <= 1'b0;
      overdue_q   <= 1'b0;
      guard_q     <= GuardMax;
      refcnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      cs_q        <= cs_d;
      pat_q       <= pat_d;
      beat2_q     <= beat2_d;
      beat2_act_q <= beat2_act_d;
      pd_q        <= pd_d;
      err_q       <= err_d;
      due_q       <= (refcnt_q >= RefDue);
      overdue_q   <= (refcnt_q >= RefMax);
      guard_q     <= guard_d;
      refcnt_q    <= refcnt_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 7; i++) begin
      ca_o[i] = pat_q[6-i];
    end
  end

  assign cs_o          = cs_q;
  assign pd_o          = pd_q;
  assign err_o         = err_q;
  assign ref_due_o     = due_q;
  assign ref_overdue_o = overdue_q;

endmodule

// File: tb/tb_gp_lpddr5_ca_cmd_encoder.sv
// Scoreboard bench for gp_lpddr5_ca_cmd_encoder: stimulus queues expected CS/CA beats,
// a negedge monitor pops and compares every non-DES pin cycle.
module tb_gp_lpddr5_ca_cmd_encoder;

  logic       ck_t = 1'b0;
  logic       ddr_reset_n;
  logic       req_valid_i;
  logic       req_ready_o;
  logic [3:0] req_cmd_i;
  logic [7:0] req_arg_i;
  logic       req_cas_i;
  logic       cs_o;
  logic [6:0] ca_o;
  logic       pd_o;
  logic       ref_due_o;
  logic       ref_overdue_o;
  logic       err_o;

  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  int         w;

  always #5 ck_t = ~ck_t;

  gp_lpddr5_ca_cmd_encoder dut (
    .ck_t          (ck_t),
    .ddr_reset_n   (ddr_reset_n),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_cmd_i     (req_cmd_i),
    .req_arg_i     (req_arg_i),
    .req_cas_i     (req_cas_i),
    .cs_o          (cs_o),
    .ca_o          (ca_o),
    .pd_o          (pd_o),
    .ref_due_o     (ref_due_o),
    .ref_overdue_o (ref_overdue_o),
    .err_o         (err_o)
  );

  // Pins back into written CA0..CA6 order (leftmost character = CA0).
  function automatic logic [6:0] pins2pat(input logic [6:0] ca);
    logic [6:0] p;
    for (int i = 0; i < 7; i++) p[6-i] = ca[i];
    return p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_beat(input logic cs, input logic [6:0] pat);
    exp_q.push_back({cs, pat});
  endtask

  task automatic step();
    @(posedge ck_t);
    #1;
  endtask

  // Returns 1ns into the cycle that shows the first beat; waited = stalled negedges.
  task automatic send(input logic [3:0] cmd, input logic [7:0] arg, input logic cas,
                      output int waited);
    req_valid_i = 1'b1;
    req_cmd_i   = cmd;
    req_arg_i   = arg;
    req_cas_i   = cas;
    waited      = 0;
    @(negedge ck_t);
    while (!req_ready_o && waited < 40) begin
      waited++;
      @(negedge ck_t);
    end
    if (!req_ready_o) check("ready_timeout", {31'b0, req_ready_o}, 32'd1);
    @(posedge ck_t);
    #1;
    req_valid_i = 1'b0;
    req_cmd_i   = 4'd0;
    req_arg_i   = 8'd0;
    req_cas_i   = 1'b0;
  endtask

  task automatic run_vec(input string name, input logic [3:0] cmd, input logic [7:0] arg,
                         input logic cas, input int nb, input logic [6:0] b1,
                         input logic [6:0] b2);
    int wt;
    expect_beat(1'b1, b1);
    if (nb == 2) expect_beat(1'b1, b2);
    send(cmd, arg, cas, wt);
    check({name, "_b1"}, {24'b0, cs_o, pins2pat(ca_o)}, {24'b0, 1'b1, b1});
    if (nb == 2) begin
      step();
      check({name, "_b2"}, {24'b0, cs_o, pins2pat(ca_o)}, {24'b0, 1'b1, b2});
    end
  endtask

  always @(negedge ck_t) begin
    if (ddr_reset_n && (cs_o || ca_o != 7'd0)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {24'b0, cs_o, pins2pat(ca_o)}, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("mon_beat", {24'b0, cs_o, pins2pat(ca_o)}, {24'b0, mon_exp});
      end
    end
  end

  initial begin
    ddr_reset_n = 1'b1;
    req_valid_i = 1'b0;
    req_cmd_i   = 4'd0;
    req_arg_i   = 8'd0;
    req_cas_i   = 1'b0;
    #2 ddr_reset_n = 1'b0;
    #1;
    check("rst_cs", {31'b0, cs_o}, 32'd0);
    check("rst_ca", {25'b0, ca_o}, 32'd0);
    check("rst_flags", {28'b0, pd_o, ref_due_o, ref_overdue_o, err_o}, 32'd0);
    check("rst_ready", {31'b0, req_ready_o}, 32'd0);
    @(posedge ck_t);
    @(negedge ck_t);
    ddr_reset_n = 1'b1;
    step();

    // ACT A5
    expect_beat(1'b1, 7'b1111010);
    expect_beat(1'b1, 7'b1100101);
    send(4'd1, 8'hA5, 1'b0, w);
    check("act_b1", {24'b0, cs_o, pins2pat(ca_o)}, {24'b0, 8'b11111010});
    check("act_ready_beat2", {31'b0, req_ready_o}, 32'd0);
    step();
    check("act_b2", {24'b0, cs_o, pins2pat(ca_o)}, {24'b0, 8'b11100101});
    check("act_ready_after", {31'b0, req_ready_o}, 32'd1);
    step();
    check("act_des", {24'b0, cs_o, ca_o}, 32'd0);

    // ACT then REF immediately: REF stalls until the guard elapses
    expect_beat(1'b1, 7'b1110001);
    expect_beat(1'b1, 7'b1100010);
    send(4'd1, 8'h12, 1'b0, w);
    expect_beat(1'b1, 7'b0001110);
    send(4'd3, 8'h00, 1'b0, w);
    check("ref_guard_stall", w, 32'd7);
    check("ref_beat", {24'b0, cs_o, pins2pat(ca_o)}, {24'b0, 8'b10001110});
    step();

    run_vec("wr16_cas", 4'd4, 8'h03, 1'b1, 2, 7'b0011100, 7'b0110011);
    run_vec("rd32_cas", 4'd8, 8'h01, 1'b1, 2, 7'b0011010, 7'b1010001);
    run_vec("wr32", 4'd5, 8'h05, 1'b0, 1, 7'b0010101, 7'b0);
    run_vec("mwr_cas", 4'd6, 8'h0A, 1'b1, 2, 7'b0011100, 7'b0101010);
    run_vec("rd16", 4'd7, 8'h0C, 1'b0, 1, 7'b1001100, 7'b0);
    run_vec("mrw", 4'd9, 8'h01, 1'b0, 2, 7'b0001101, 7'b0001001);
    run_vec("pre", 4'd2, 8'h00, 1'b0, 1, 7'b0001111, 7'b0);
    run_vec("mrr", 4'd10, 8'h00, 1'b0, 1, 7'b0001100, 7'b0);
    run_vec("wff", 4'd11, 8'h00, 1'b0, 1, 7'b0000011, 7'b0);
    run_vec("rff", 4'd12, 8'h00, 1'b0, 1, 7'b0000010, 7'b0);
    run_vec("casfs_cas_ignored", 4'd13, 8'h00, 1'b1, 1, 7'b0011001, 7'b0);
    run_vec("nop", 4'd0, 8'h00, 1'b0, 1, 7'b0000000, 7'b0);
    step();
    step();

    // PDX in IDLE is dropped
    send(4'd15, 8'h00, 1'b0, w);
    check("pdx_idle_err", {31'b0, err_o}, 32'd1);
    check("pdx_idle_des", {24'b0, cs_o, ca_o}, 32'd0);
    step();
    check("pdx_idle_err_pulse", {31'b0, err_o}, 32'd0);

    // Power-down entry, illegal request, exit
    expect_beat(1'b1, 7'b0000001);
    send(4'd14, 8'h00, 1'b0, w);
    check("pde_beat", {24'b0, cs_o, pins2pat(ca_o)}, {24'b0, 8'b10000001});
    step();
    check("pd_pins", {24'b0, cs_o, ca_o}, 32'd0);
    check("pd_flag", {31'b0, pd_o}, 32'd1);
    send(4'd7, 8'h03, 1'b0, w);
    check("pd_rd16_err", {31'b0, err_o}, 32'd1);
    check("pd_rd16_pins", {24'b0, cs_o, ca_o}, 32'd0);
    step();
    check("pd_err_pulse", {31'b0, err_o}, 32'd0);
    expect_beat(1'b0, 7'b0000001);
    send(4'd15, 8'h00, 1'b0, w);
    check("pdx_beat", {24'b0, cs_o, pins2pat(ca_o)}, {24'b0, 8'b00000001});
    check("pdx_ready", {31'b0, req_ready_o}, 32'd0);
    step();
    check("pdx_pd_clear", {31'b0, pd_o}, 32'd0);
    check("pdx_des", {24'b0, cs_o, ca_o}, 32'd0);
    check("pdx_ready_after", {31'b0, req_ready_o}, 32'd1);

    // Reset during ACT beat1
    send(4'd1, 8'h3C, 1'b0, w);
    check("rst_mid_b1", {24'b0, cs_o, pins2pat(ca_o)}, {24'b0, 8'b11110011});
    ddr_reset_n = 1'b0;
    #1;
    check("rst_mid_async", {24'b0, cs_o, ca_o}, 32'd0);
    @(posedge ck_t);
    @(negedge ck_t);
    ddr_reset_n = 1'b1;
    check("rst_mid_due", {30'b0, ref_due_o, ref_overdue_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_mid_no_b2", {24'b0, cs_o, ca_o}, 32'd0);
    end

    // Refresh interval: counter equals edge count since reset release
    repeat (61) @(posedge ck_t);
    #1;
    check("due_at_64", {31'b0, ref_due_o}, 32'd0);
    step();
    check("due_at_65", {31'b0, ref_due_o}, 32'd1);
    check("overdue_at_65", {31'b0, ref_overdue_o}, 32'd0);
    repeat (63) @(posedge ck_t);
    #1;
    check("overdue_at_128", {31'b0, ref_overdue_o}, 32'd0);
    step();
    check("overdue_at_129", {31'b0, ref_overdue_o}, 32'd1);
    expect_beat(1'b1, 7'b0001110);
    send(4'd3, 8'h00, 1'b0, w);
    check("ref_no_stall", w, 32'd0);
    check("due_in_ref_beat", {31'b0, ref_due_o}, 32'd1);
    step();
    check("due_after_ref", {30'b0, ref_due_o, ref_overdue_o}, 32'd0);

    step();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
